// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the vending machine controllers.
// The coin front end uses the same coin codes.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_FAULT   = 3'd4
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_15   = 2'b11;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 4'd5;
            COIN_10: return 4'd10;
            COIN_15: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TIMEOUT.
module vend_watchdog #(
    parameter int TIMEOUT = 200_000_000,
    parameter int TW      = 28
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Owner leaves the guarded state on this edge, so the counter never wraps.
    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Transaction controller for the newspaper vending machine: coin credit,
// dispense and change-return sequencing with a handshake watchdog.
//
// state   | meaning
// IDLE    | no credit, waiting for the first coin
// COLLECT | 0 < credit < PRICE, accepting coins or cancel
// VEND    | disp_req high, waiting for disp_done
// CHANGE  | chg_req high with chg_amount, waiting for chg_done
// FAULT   | actuator timed out, credit held until fault_clr
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int PRICE   = 15,
    parameter int CW      = 6,
    parameter int TIMEOUT = 200_000_000,
    parameter int TW      = 28
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          coin_valid,
    input  logic [1:0]    coin_sel,
    input  logic          cancel,
    input  logic          disp_done,
    input  logic          chg_done,
    input  logic          fault_clr,
    output logic          disp_req,
    output logic          chg_req,
    output logic [CW-1:0] chg_amount,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          busy,
    output logic          fault,
    output logic [15:0]   vend_count
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    vend_state_e   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] chg_amount_q, chg_amount_d;
    logic [15:0]   vend_count_q, vend_count_d;
    logic          coin_reject_q, coin_reject_d;

    logic          accepting;
    logic          coin_ok;
    logic [CW-1:0] coin_amt;
    logic [CW-1:0] credit_sum;
    logic          wd_clear;
    logic          wd_enable;
    logic          wd_expired;

    assign accepting  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign coin_ok    = coin_valid && (coin_sel != COIN_NONE) && !cancel && accepting;
    assign coin_amt   = CW'(coin_value(coin_sel));
    assign credit_sum = credit_q + coin_amt;

    // Restart the watchdog on every entry into a handshake state.
    assign wd_clear  = ((state_d == ST_VEND)   && (state_q != ST_VEND)) ||
                       ((state_d == ST_CHANGE) && (state_q != ST_CHANGE));
    assign wd_enable = (state_q == ST_VEND) || (state_q == ST_CHANGE);

    vend_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            chg_amount_q  <= '0;
            vend_count_q  <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            chg_amount_q  <= chg_amount_d;
            vend_count_q  <= vend_count_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        chg_amount_d  = chg_amount_q;
        vend_count_d  = vend_count_q;
        coin_reject_d = coin_valid && !coin_ok;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                // Cancel beats a simultaneous coin; the coin is rejected above.
                if ((state_q == ST_COLLECT) && cancel) begin
                    chg_amount_d = credit_q;
                    state_d      = ST_CHANGE;
                end else if (coin_ok) begin
                    credit_d = credit_sum;
                    state_d  = (credit_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
                end
            end
            ST_VEND: begin
                if (disp_done) begin
                    vend_count_d = vend_count_q + 16'd1;
                    if (credit_q > PRICE_C) begin
                        chg_amount_d = credit_q - PRICE_C;
                        state_d      = ST_CHANGE;
                    end else begin
                        chg_amount_d = '0;
                        credit_d     = '0;
                        state_d      = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_CHANGE: begin
                if (chg_done) begin
                    credit_d     = '0;
                    chg_amount_d = '0;
                    state_d      = ST_IDLE;
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    credit_d     = '0;
                    chg_amount_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        disp_req = (state_q == ST_VEND);
        chg_req  = (state_q == ST_CHANGE);
        fault    = (state_q == ST_FAULT);
        busy     = (state_q == ST_VEND) || (state_q == ST_CHANGE) || (state_q == ST_FAULT);
    end

    assign credit      = credit_q;
    assign chg_amount  = chg_amount_q;
    assign vend_count  = vend_count_q;
    assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler with PRICE=15, TIMEOUT=16.
module tb_vend_dispense_scheduler;

    localparam int P  = 15;
    localparam int CW = 6;
    localparam int TO = 16;
    localparam int TW = 8;

    logic          clk;
    logic          reset_n;
    logic          coin_valid;
    logic [1:0]    coin_sel;
    logic          cancel;
    logic          disp_done;
    logic          chg_done;
    logic          fault_clr;
    logic          disp_req;
    logic          chg_req;
    logic [CW-1:0] chg_amount;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          busy;
    logic          fault;
    logic [15:0]   vend_count;

    int errors = 0;
    int checks = 0;
    int exp_vends = 0;

    vend_dispense_scheduler #(
        .PRICE   (P),
        .CW      (CW),
        .TIMEOUT (TO),
        .TW      (TW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .cancel      (cancel),
        .disp_done   (disp_done),
        .chg_done    (chg_done),
        .fault_clr   (fault_clr),
        .disp_req    (disp_req),
        .chg_req     (chg_req),
        .chg_amount  (chg_amount),
        .credit      (credit),
        .coin_reject (coin_reject),
        .busy        (busy),
        .fault       (fault),
        .vend_count  (vend_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_sel   = code;
        tick();
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    task automatic pulse_disp();
        disp_done = 1'b1; tick(); disp_done = 1'b0;
    endtask

    task automatic pulse_chg();
        chg_done = 1'b1; tick(); chg_done = 1'b0;
    endtask

    task automatic pulse_fault_clr();
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; coin_valid = 0; coin_sel = 0; cancel = 0;
        disp_done = 0; chg_done = 0; fault_clr = 0;
        #23;
        checks++;
        if ({disp_req, chg_req, coin_reject, busy, fault} !== 5'b0 || credit !== 0 ||
            chg_amount !== 0 || vend_count !== 0) begin
            errors++;
            $display("FAIL reset_state: got req=%b chg=%b rej=%b busy=%b fault=%b credit=%0d amt=%0d cnt=%0d want all zero",
                     disp_req, chg_req, coin_reject, busy, fault, credit, chg_amount, vend_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_vend();
        coin(2'b01);
        checks++; if (credit !== 5 || busy !== 0 || coin_reject !== 0) begin errors++;
            $display("FAIL exact_first_coin: got credit=%0d busy=%b rej=%b want 5 0 0", credit, busy, coin_reject); end
        coin(2'b10);
        checks++; if (credit !== 15 || disp_req !== 1 || chg_req !== 0) begin errors++;
            $display("FAIL exact_enter_vend: got credit=%0d req=%b chg=%b want 15 1 0", credit, disp_req, chg_req); end
        ticks(2);
        checks++; if (disp_req !== 1) begin errors++;
            $display("FAIL exact_req_held: got %b want 1", disp_req); end
        pulse_disp();
        exp_vends++;
        checks++; if (disp_req !== 0 || chg_req !== 0 || credit !== 0 || busy !== 0 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL exact_done: got req=%b chg=%b credit=%0d busy=%b cnt=%0d want 0 0 0 0 %0d",
                     disp_req, chg_req, credit, busy, vend_count, exp_vends); end
    endtask

    task automatic test_vend_with_change();
        coin(2'b10);
        coin(2'b10);
        checks++; if (credit !== 20 || disp_req !== 1) begin errors++;
            $display("FAIL change_enter_vend: got credit=%0d req=%b want 20 1", credit, disp_req); end
        pulse_disp();
        exp_vends++;
        tick();
        checks++; if (chg_req !== 1 || chg_amount !== 5 || disp_req !== 0 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL change_request: got chg=%b amt=%0d req=%b cnt=%0d want 1 5 0 %0d",
                     chg_req, chg_amount, disp_req, vend_count, exp_vends); end
        pulse_chg();
        checks++; if (chg_req !== 0 || credit !== 0 || chg_amount !== 0 || busy !== 0) begin errors++;
            $display("FAIL change_done: got chg=%b credit=%0d amt=%0d busy=%b want 0 0 0 0", chg_req, credit, chg_amount, busy); end
    endtask

    task automatic test_cancel_refund();
        coin(2'b01);
        pulse_cancel();
        checks++; if (chg_req !== 1 || chg_amount !== 5 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL cancel_refund: got chg=%b amt=%0d cnt=%0d want 1 5 %0d", chg_req, chg_amount, vend_count, exp_vends); end
        coin(2'b10);
        checks++; if (coin_reject !== 1 || credit !== 5) begin errors++;
            $display("FAIL coin_in_change: got rej=%b credit=%0d want 1 5", coin_reject, credit); end
        tick();
        checks++; if (coin_reject !== 0) begin errors++;
            $display("FAIL reject_one_cycle: got %b want 0", coin_reject); end
        pulse_chg();
        checks++; if (busy !== 0 || credit !== 0) begin errors++;
            $display("FAIL cancel_close: got busy=%b credit=%0d want 0 0", busy, credit); end
    endtask

    task automatic test_timeout_fault();
        int early = 0;
        coin(2'b11);
        for (int i = 1; i < TO; i++) begin
            tick();
            if (disp_req !== 1 || fault !== 0) early++;
        end
        checks++; if (early != 0) begin errors++;
            $display("FAIL timeout_early: got %0d premature cycles want 0", early); end
        tick();
        checks++; if (fault !== 1 || disp_req !== 0 || busy !== 1 || credit !== 15) begin errors++;
            $display("FAIL timeout_fault: got fault=%b req=%b busy=%b credit=%0d want 1 0 1 15", fault, disp_req, busy, credit); end
        coin(2'b01);
        checks++; if (coin_reject !== 1 || credit !== 15) begin errors++;
            $display("FAIL coin_in_fault: got rej=%b credit=%0d want 1 15", coin_reject, credit); end
        pulse_disp();
        checks++; if (fault !== 1 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL spurious_done_fault: got fault=%b cnt=%0d want 1 %0d", fault, vend_count, exp_vends); end
        pulse_fault_clr();
        checks++; if (fault !== 0 || busy !== 0 || credit !== 0) begin errors++;
            $display("FAIL fault_clear: got fault=%b busy=%b credit=%0d want 0 0 0", fault, busy, credit); end
    endtask

    task automatic test_done_at_expiry();
        coin(2'b11);
        ticks(TO - 1);
        pulse_disp();
        exp_vends++;
        checks++; if (fault !== 0 || busy !== 0 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL done_at_expiry: got fault=%b busy=%b cnt=%0d want 0 0 %0d", fault, busy, vend_count, exp_vends); end
    endtask

    task automatic test_reject_cases();
        coin(2'b00);
        checks++; if (coin_reject !== 1 || credit !== 0 || busy !== 0) begin errors++;
            $display("FAIL invalid_code: got rej=%b credit=%0d busy=%b want 1 0 0", coin_reject, credit, busy); end
        coin(2'b01);
        coin(2'b00);
        checks++; if (coin_reject !== 1 || credit !== 5) begin errors++;
            $display("FAIL invalid_in_collect: got rej=%b credit=%0d want 1 5", coin_reject, credit); end
        coin_valid = 1'b1; coin_sel = 2'b10; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; coin_sel = 2'b00; cancel = 1'b0;
        checks++; if (coin_reject !== 1 || chg_req !== 1 || chg_amount !== 5 || credit !== 5) begin errors++;
            $display("FAIL coin_with_cancel: got rej=%b chg=%b amt=%0d credit=%0d want 1 1 5 5", coin_reject, chg_req, chg_amount, credit); end
        pulse_chg();
        pulse_disp();
        pulse_chg();
        pulse_cancel();
        checks++; if (busy !== 0 || disp_req !== 0 || chg_req !== 0 || vend_count !== 16'(exp_vends)) begin errors++;
            $display("FAIL spurious_idle: got busy=%b req=%b chg=%b cnt=%0d want 0 0 0 %0d", busy, disp_req, chg_req, vend_count, exp_vends); end
    endtask

    task automatic test_reset_midvend();
        coin(2'b11);
        checks++; if (disp_req !== 1) begin errors++;
            $display("FAIL midvend_setup: got req=%b want 1", disp_req); end
        reset_n = 1'b0;
        #1;
        exp_vends = 0;
        checks++; if (disp_req !== 0 || credit !== 0 || busy !== 0 || vend_count !== 0) begin errors++;
            $display("FAIL async_reset: got req=%b credit=%0d busy=%b cnt=%0d want 0 0 0 0", disp_req, credit, busy, vend_count); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        coin(2'b11);
        pulse_disp();
        exp_vends++;
        checks++; if (vend_count !== 16'(exp_vends) || busy !== 0) begin errors++;
            $display("FAIL after_reset_vend: got cnt=%0d busy=%b want %0d 0", vend_count, busy, exp_vends); end
    endtask

    // Reference: credit is the running sum of accepted coin values (5 * code);
    // the change owed is whatever exceeds the price.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int sum = 0;
            if ($urandom_range(0, 4) == 0) begin
                int code = $urandom_range(1, 2);
                coin(2'(code));
                sum = 5 * code;
                pulse_cancel();
                checks++; if (chg_req !== 1 || chg_amount !== CW'(sum) || vend_count !== 16'(exp_vends)) begin errors++;
                    $display("FAIL rnd_cancel t=%0d: got chg=%b amt=%0d cnt=%0d want 1 %0d %0d", t, chg_req, chg_amount, vend_count, sum, exp_vends); end
                ticks($urandom_range(0, 3));
                pulse_chg();
            end else begin
                while (sum < P) begin
                    if ($urandom_range(0, 4) == 0) begin
                        coin(2'b00);
                        checks++; if (coin_reject !== 1 || credit !== CW'(sum)) begin errors++;
                            $display("FAIL rnd_invalid t=%0d: got rej=%b credit=%0d want 1 %0d", t, coin_reject, credit, sum); end
                    end else begin
                        int code = $urandom_range(1, 3);
                        coin(2'(code));
                        sum += 5 * code;
                        checks++; if (credit !== CW'(sum) || coin_reject !== 0 || disp_req !== (sum >= P)) begin errors++;
                            $display("FAIL rnd_credit t=%0d: got credit=%0d rej=%b req=%b want %0d 0 %b", t, credit, coin_reject, disp_req, sum, (sum >= P)); end
                    end
                end
                ticks($urandom_range(0, 5));
                pulse_disp();
                exp_vends++;
                checks++; if (vend_count !== 16'(exp_vends) || disp_req !== 0 || chg_req !== (sum > P)) begin errors++;
                    $display("FAIL rnd_vend t=%0d: got cnt=%0d req=%b chg=%b want %0d 0 %b", t, vend_count, disp_req, chg_req, exp_vends, (sum > P)); end
                if (sum > P) begin
                    checks++; if (chg_amount !== CW'(sum - P)) begin errors++;
                        $display("FAIL rnd_change t=%0d: got amt=%0d want %0d", t, chg_amount, sum - P); end
                    ticks($urandom_range(0, 3));
                    pulse_chg();
                end
            end
            checks++; if (busy !== 0 || credit !== 0 || chg_amount !== 0) begin errors++;
                $display("FAIL rnd_idle t=%0d: got busy=%b credit=%0d amt=%0d want 0 0 0", t, busy, credit, chg_amount); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_with_change();
        test_cancel_refund();
        test_timeout_fault();
        test_done_at_expiry();
        test_reject_cases();
        test_reset_midvend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_dispense_scheduler.md
Name: vend_dispense_scheduler

Overview:
Transaction controller for the newspaper vending machine.
- Accepts already-debounced, single-cycle coin events and accumulates credit against a configurable price.
- Sequences the dispenser actuator, then the change-return actuator, over req/done handshakes, with a watchdog timeout.
- Sits between the coin front end (sync/debounce/edge detect) and the actuator drivers. The LED/display logic reads its credit and status outputs.

Parameters:
PRICE, 15, newspaper price in rupees; multiple of 5, range 5..40
CW, 6, width of credit and change values; must hold PRICE+10
TIMEOUT, 200_000_000, handshake watchdog in clk cycles (2 s at 100 MHz)
TW, 28, width of the watchdog counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous, active-low reset
coin_valid  in  1  single-cycle coin event
coin_sel  in  2  coin code: 01=5, 10=10, 11=15, 00=invalid
cancel  in  1  single-cycle refund request
disp_done  in  1  dispenser completion pulse
chg_done  in  1  change-return completion pulse
fault_clr  in  1  single-cycle fault acknowledge
disp_req  out  1  dispenser request
chg_req  out  1  change-return request
chg_amount  out  CW  rupees to return, valid while chg_req=1
credit  out  CW  current accumulated credit
coin_reject  out  1  one-cycle pulse: coin event refused
busy  out  1  high in VEND, CHANGE or FAULT
fault  out  1  high in FAULT
vend_count  out  16  completed vends; wraps at 65535->0

Behaviour:
- Reset (async assert, sync release): state=IDLE. credit, chg_amount, vend_count and watchdog = 0. All 1-bit outputs = 0.
- Outputs are registered or decoded from registered state only. There is no combinational input-to-output path.
- States: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, CHANGE, FAULT.
- Coin acceptance:
  - In IDLE/COLLECT, a coin_valid with a valid code adds 5/10/15 to credit on the next edge.
  - If the new credit >= PRICE, go to VEND. Otherwise go to or stay in COLLECT.
- Coin rejection: coin_reject pulses the cycle after coin_valid when any of these holds:
  - coin_sel=00;
  - state is VEND, CHANGE or FAULT;
  - the coin coincides with cancel.
  A rejected coin never changes credit.
- cancel:
  - In COLLECT: chg_amount<=credit and go to CHANGE as a refund; vend_count is unchanged.
  - Ignored in IDLE, VEND, CHANGE and FAULT.
  - cancel together with coin_valid in COLLECT: cancel wins and the coin is rejected.
- VEND:
  - disp_req=1 from the first VEND cycle and stays high until disp_done is sampled.
  - On disp_done: vend_count+1 and chg_amount<=credit-PRICE. If that amount is >0, go to CHANGE; otherwise credit<=0 and go to IDLE.
  - disp_req drops in the cycle after disp_done.
- CHANGE:
  - chg_req=1 and chg_amount is held stable until chg_done.
  - On chg_done: credit<=0, chg_amount<=0, go to IDLE.
- Watchdog:
  - Cleared on entry to VEND or CHANGE; increments each cycle in those states.
  - Reaching TIMEOUT with no done goes to FAULT with disp_req=chg_req=0.
  - A done in the same cycle as expiry wins; no fault.
- FAULT:
  - fault=1; credit is held for inspection.
  - fault_clr clears credit and chg_amount and goes to IDLE.
  - Coins are rejected.
- Spurious disp_done/chg_done outside their own states: ignored.
- Arithmetic is unsigned. credit+coin never exceeds PRICE+10, so there is no overflow for legal PRICE.
- reset_n low mid-VEND/CHANGE: requests drop immediately (async) and credit is lost; this is intended.

Decomposition:
- Shared package vend_pkg:
  - state enum;
  - coin code localparams;
  - a function coin_value(code) returning 0/5/10/15.
  The coin front end reuses the coin codes.
- One sub-module, vend_watchdog: clear/enable inputs, expired output, parameters TIMEOUT and TW. It is reused by later actuator blocks.

Test Plan:
- PRICE=15: coin 5 then coin 10, disp_done 3 cycles after disp_req -> credit 5 then 15, disp_req high, no chg_req, IDLE, vend_count=1.
- PRICE=15: coin 10 then coin 10 -> VEND. After disp_done: chg_req=1, chg_amount=5. After chg_done: credit=0, IDLE.
- coin 5 then cancel -> CHANGE with chg_amount=5, vend_count unchanged. Then coin 10 during CHANGE -> coin_reject pulse, credit stays 5.
- TIMEOUT=16: reach VEND and never assert disp_done -> fault=1 and disp_req=0 after 16 cycles. fault_clr -> IDLE, credit=0.
- coin_valid with coin_sel=00, and coin_valid together with cancel in COLLECT -> coin_reject each time; credit unchanged except for the cancel refund.
- reset_n low while disp_req=1 -> disp_req=0, credit=0 and state=IDLE immediately. After release, a coin 15 vends normally.
